// File: rtl/io_timers_pkg.sv
// io_timers_pkg: register offsets, CTRL/STATUS bit positions and the ctrl struct shared by the timer block
package io_timers_pkg;
    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_STATUS    = 3'd1;
    localparam logic [2:0] OFF_RELOAD_LO = 3'd2;
    localparam logic [2:0] OFF_RELOAD_HI = 3'd3;
    localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
    localparam logic [2:0] OFF_COUNT_HI  = 3'd5;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;
    localparam int CTRL_PSEL   = 4;
    localparam int STATUS_TF   = 0;
    localparam int STATUS_RUN  = 1;
    typedef struct packed {
        logic [2:0] psel;
        logic       ie;
        logic       reload;
        logic       en;
    } ctrl_t;
endpackage

// File: rtl/io_timer_channel.sv
// io_timer_channel: one 16-bit down-counting timer (prescaler, counter, TF, count staging/shadow) driven by decoded register strobes
module io_timer_channel
    import io_timers_pkg::*;
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  data,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic        wr_reload_lo,
    input  logic        wr_reload_hi,
    input  logic        wr_count_lo,
    input  logic        wr_count_hi,
    input  logic        rd_count_lo,
    output ctrl_t       ctrl,
    output logic        tf,
    output logic [15:0] count,
    output logic [15:0] reload,
    output logic [7:0]  shadow,
    output logic        irq
);
    logic [6:0] psc;
    logic [7:0] stage;
    logic       tick;
    logic       under;
    assign tick  = ctrl.en && !wr_ctrl && psc == (7'd1 << ctrl.psel) - 7'd1;
    assign under = tick && count == 16'd0;
    assign irq   = tf && ctrl.ie;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl   <= '0;
            tf     <= 1'b0;
            count  <= '0;
            reload <= '0;
            shadow <= '0;
            stage  <= '0;
            psc    <= '0;
        end else begin
            psc <= (wr_ctrl || !ctrl.en || tick) ? 7'd0 : psc + 7'd1;
            if (wr_ctrl)
                ctrl <= '{psel: data[CTRL_PSEL+:3], ie: data[CTRL_IE], reload: data[CTRL_RELOAD], en: data[CTRL_EN]};
            else if (under && !ctrl.reload)
                ctrl.en <= 1'b0;
            tf <= under ? 1'b1 : (wr_status && data[STATUS_TF]) ? 1'b0 : tf;
            if (wr_reload_lo)
                reload[7:0] <= data;
            if (wr_reload_hi)
                reload[15:8] <= data;
            if (wr_count_lo)
                stage <= data;
            if (wr_count_hi)
                count <= {data, stage};
            else if (tick)
                count <= count != 16'd0 ? count - 16'd1 : ctrl.reload ? reload : count;
            if (rd_count_lo)
                shadow <= count[15:8];
        end
    end
endmodule

// File: rtl/io_timers.sv
// io_timers: IO-bus responder with NUM_TIMERS timers at 8n..8n+7; bus_* in, bus_out read mux, irq per timer
module io_timers
    import io_timers_pkg::*;
#(
    parameter int NUM_TIMERS = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  bus_cyc,
    input  logic                  bus_we,
    input  logic [5:0]            bus_addr,
    input  logic [7:0]            bus_data_in,
    output logic [7:0]            bus_out,
    output logic [NUM_TIMERS-1:0] irq
);
    logic [2:0] ch;
    logic [2:0] off;
    logic [7:0] rd [8];
    assign ch  = bus_addr[5:3];
    assign off = bus_addr[2:0];
    genvar n;
    generate
        for (n = 0; n < 8; n++) begin : g_ch
            if (n < NUM_TIMERS) begin : g_on
                logic        sel;
                logic        wr;
                ctrl_t       ctrl;
                logic        tf;
                logic [15:0] count;
                logic [15:0] reload;
                logic [7:0]  shadow;
                assign sel = bus_cyc && ch == 3'(n);
                assign wr  = sel && bus_we;
                io_timer_channel u_ch (
                    .wb_clk_i     (wb_clk_i),
                    .wb_rst_i     (wb_rst_i),
                    .data         (bus_data_in),
                    .wr_ctrl      (wr && off == OFF_CTRL),
                    .wr_status    (wr && off == OFF_STATUS),
                    .wr_reload_lo (wr && off == OFF_RELOAD_LO),
                    .wr_reload_hi (wr && off == OFF_RELOAD_HI),
                    .wr_count_lo  (wr && off == OFF_COUNT_LO),
                    .wr_count_hi  (wr && off == OFF_COUNT_HI),
                    .rd_count_lo  (sel && !bus_we && off == OFF_COUNT_LO),
                    .ctrl         (ctrl),
                    .tf           (tf),
                    .count        (count),
                    .reload       (reload),
                    .shadow       (shadow),
                    .irq          (irq[n])
                );
                assign rd[n] = off == OFF_CTRL      ? {1'b0, ctrl.psel, 1'b0, ctrl.ie, ctrl.reload, ctrl.en} :
                               off == OFF_STATUS    ? {6'b0, ctrl.en, tf} :
                               off == OFF_RELOAD_LO ? reload[7:0] :
                               off == OFF_RELOAD_HI ? reload[15:8] :
                               off == OFF_COUNT_LO  ? count[7:0] :
                               off == OFF_COUNT_HI  ? shadow : 8'h00;
            end else begin : g_off
                assign rd[n] = 8'h00;
            end
        end
    endgenerate
    assign bus_out = rd[ch];
endmodule

// File: tb/tb_io_timers.sv
// tb_io_timers: directed self-checking bench for io_timers with NUM_TIMERS=2
module tb_io_timers;
    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       bus_cyc = 1'b0;
    logic       bus_we = 1'b0;
    logic [5:0] bus_addr = '0;
    logic [7:0] bus_data_in = '0;
    logic [7:0] bus_out;
    logic [1:0] irq;
    int checks = 0;
    int failures = 0;
    io_timers #(.NUM_TIMERS(2)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .bus_cyc     (bus_cyc),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_data_in (bus_data_in),
        .bus_out     (bus_out),
        .irq         (irq)
    );
    always #5 wb_clk_i = ~wb_clk_i;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus_cyc = 1'b1;
        bus_we = 1'b1;
        bus_addr = a;
        bus_data_in = d;
        step();
        bus_cyc = 1'b0;
        bus_we = 1'b0;
    endtask
    task automatic peek(input string tag, input logic [5:0] a, input logic [7:0] exp);
        bus_addr = a;
        #1;
        chk(tag, bus_out, exp);
    endtask
    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
        bus_cyc = 1'b1;
        bus_we = 1'b0;
        bus_addr = a;
        #1;
        chk(tag, bus_out, exp);
        step();
        bus_cyc = 1'b0;
    endtask
    initial begin
        repeat (3) step();
        wb_rst_i = 1'b0;
        for (int i = 0; i < 64; i++) peek($sformatf("reset_rd_%0d", i), 6'(i), 8'h00);
        chk("reset_irq", irq, 2'b00);
        wr(6'h02, 8'h03);
        wr(6'h03, 8'h00);
        wr(6'h04, 8'h03);
        wr(6'h05, 8'h00);
        wr(6'h00, 8'h07);
        peek("per_cnt3", 6'h04, 8'h03);
        step();
        peek("per_cnt2", 6'h04, 8'h02);
        step();
        peek("per_cnt1", 6'h04, 8'h01);
        step();
        peek("per_cnt0", 6'h04, 8'h00);
        chk("per_irq_pre", irq, 2'b00);
        step();
        peek("per_reload", 6'h04, 8'h03);
        peek("per_status", 6'h01, 8'h03);
        chk("per_irq", irq, 2'b01);
        wr(6'h01, 8'h01);
        peek("w1c_status", 6'h01, 8'h02);
        chk("w1c_irq", irq, 2'b00);
        step();
        step();
        wr(6'h01, 8'h01);
        peek("w1c_vs_set_status", 6'h01, 8'h03);
        peek("w1c_vs_set_cnt", 6'h04, 8'h03);
        wr(6'h01, 8'h01);
        peek("w1c_again", 6'h01, 8'h02);
        wr(6'h00, 8'h00);
        peek("ctrl_wins_cnt", 6'h04, 8'h02);
        peek("ctrl_off", 6'h00, 8'h00);
        wr(6'h0C, 8'h01);
        wr(6'h0D, 8'h00);
        wr(6'h08, 8'h21);
        peek("os_ctrl", 6'h08, 8'h21);
        step();
        step();
        step();
        peek("os_cnt_e3", 6'h0C, 8'h01);
        step();
        peek("os_cnt_e4", 6'h0C, 8'h00);
        peek("os_stat_e4", 6'h09, 8'h02);
        step();
        step();
        step();
        peek("os_stat_e7", 6'h09, 8'h02);
        step();
        peek("os_stat_e8", 6'h09, 8'h01);
        peek("os_ctrl_e8", 6'h08, 8'h20);
        peek("os_cnt_e8", 6'h0C, 8'h00);
        chk("os_irq", irq, 2'b00);
        wr(6'h04, 8'h00);
        wr(6'h05, 8'h01);
        wr(6'h00, 8'h01);
        rd("atom_lo", 6'h04, 8'h00);
        peek("atom_shadow", 6'h05, 8'h01);
        peek("atom_live_lo", 6'h04, 8'hFF);
        wr(6'h00, 8'h00);
        wr(6'h04, 8'h34);
        peek("atom_stage_only", 6'h04, 8'hFF);
        wr(6'h05, 8'h12);
        peek("atom_load_lo", 6'h04, 8'h34);
        rd("atom_load_rd", 6'h04, 8'h34);
        peek("atom_load_hi", 6'h05, 8'h12);
        wr(6'h00, 8'h01);
        wr(6'h04, 8'h00);
        wr(6'h05, 8'h50);
        peek("hi_vs_tick_lo", 6'h04, 8'h00);
        rd("hi_vs_tick_rd", 6'h04, 8'h00);
        peek("hi_vs_tick_hi", 6'h05, 8'h50);
        wr(6'h00, 8'h00);
        wr(6'h10, 8'hFF);
        wr(6'h3F, 8'hFF);
        wr(6'h06, 8'hFF);
        peek("oob_10", 6'h10, 8'h00);
        peek("oob_3f", 6'h3F, 8'h00);
        peek("off6", 6'h06, 8'h00);
        peek("oob_t0_ctrl", 6'h00, 8'h00);
        peek("oob_t0_rld", 6'h02, 8'h03);
        peek("oob_t1_ctrl", 6'h08, 8'h20);
        peek("oob_t1_stat", 6'h09, 8'h01);
        peek("oob_t1_rld", 6'h0A, 8'h00);
        wr(6'h00, 8'h07);
        step();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        peek("rst_t0_ctrl", 6'h00, 8'h00);
        peek("rst_t0_cnt", 6'h04, 8'h00);
        peek("rst_t0_shadow", 6'h05, 8'h00);
        peek("rst_t1_stat", 6'h09, 8'h00);
        chk("rst_irq", irq, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
